// File: rtl/gpi_rx_pkg.sv
// Shared types and encodings for the GPIO receive filter.
package gpi_rx_pkg;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_STABLE  = 2'd2,
        ST_QUALIFY = 2'd3
    } state_e;

    localparam logic [1:0] PULL_NONE     = 2'b00;
    localparam logic [1:0] PULL_DOWN     = 2'b01;
    localparam logic [1:0] PULL_UP       = 2'b10;
    localparam logic [1:0] PULL_NONE_ALT = 2'b11;

    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    // True when a level change in the given direction is a selected event.
    function automatic logic edge_hit(input logic [1:0] sel, input logic rising);
        return (sel == EDGE_BOTH) || (rising ? (sel == EDGE_RISE) : (sel == EDGE_FALL));
    endfunction

endpackage

// File: rtl/gpi_rx_sync.sv
// Multi-flop synchronizer bringing the asynchronous pad input into the clock domain.
module gpi_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] stage_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpi_rx_filter.sv
// GPIO receive path: synchronizer, settle/debounce FSM, edge events and sticky IRQ.
module gpi_rx_filter
    import gpi_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             DI_I,
    output logic             IE_O,
    output logic             PE_O,
    output logic             PS_O,
    input  logic             EN_I,
    input  logic [1:0]       PULL_I,
    input  logic [CNT_W-1:0] DEB_I,
    input  logic [1:0]       EDGE_SEL_I,
    input  logic             CLR_I,
    output logic             LVL_O,
    output logic             EVT_O,
    output logic             IRQ_O
);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SYNC_STAGES);

    logic             sync;
    logic             lvl_diff_d;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             lvl_q;
    logic             evt_q;
    logic             irq_q;
    logic             ie_q;
    logic             pe_q;
    logic             ps_q;

    gpi_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i(CLK_I),
        .rst_i(RST_I),
        .d_i  (DI_I),
        .q_o  (sync)
    );

    assign lvl_diff_d = (sync != lvl_q);

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            evt_q   <= 1'b0;
            irq_q   <= 1'b0;
            ie_q    <= 1'b0;
            pe_q    <= 1'b0;
            ps_q    <= 1'b0;
        end else begin
            pe_q  <= (PULL_I == PULL_DOWN) || (PULL_I == PULL_UP);
            ps_q  <= (PULL_I == PULL_UP);
            // A pending event beats a simultaneous clear.
            irq_q <= evt_q | (irq_q & ~CLR_I);
            evt_q <= 1'b0;

            if (!EN_I) begin
                state_q <= ST_OFF;
                cnt_q   <= '0;
                lvl_q   <= 1'b0;
                ie_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_OFF: begin
                        cnt_q   <= CNT_SETTLE;
                        ie_q    <= 1'b1;
                        state_q <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (cnt_q == '0) begin
                            lvl_q   <= sync;
                            state_q <= ST_STABLE;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    ST_STABLE: begin
                        if (lvl_diff_d) begin
                            if (DEB_I == '0) begin
                                lvl_q <= sync;
                                evt_q <= edge_hit(EDGE_SEL_I, sync);
                            end else begin
                                cnt_q   <= CNT_ONE;
                                state_q <= ST_QUALIFY;
                            end
                        end
                    end
                    ST_QUALIFY: begin
                        if (!lvl_diff_d) begin
                            cnt_q   <= '0;
                            state_q <= ST_STABLE;
                        end else if (cnt_q >= DEB_I) begin
                            lvl_q   <= sync;
                            evt_q   <= edge_hit(EDGE_SEL_I, sync);
                            cnt_q   <= '0;
                            state_q <= ST_STABLE;
                        end else begin
                            // cnt_q < DEB_I here, so the increment cannot wrap.
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= ST_OFF;
                    end
                endcase
            end
        end
    end

    assign IE_O  = ie_q;
    assign PE_O  = pe_q;
    assign PS_O  = ps_q;
    assign LVL_O = lvl_q;
    assign EVT_O = evt_q;
    assign IRQ_O = irq_q;

endmodule

// File: tb/tb_gpi_rx_filter.sv
// Directed and randomized bench for gpi_rx_filter against a behavioural model.
module tb_gpi_rx_filter;

    localparam int S  = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          di;
    logic          en;
    logic          clr;
    logic [1:0]    pull;
    logic [1:0]    edge_sel;
    logic [CW-1:0] deb;
    logic          ie, pe, ps, lvl, evt, irq;

    int n_pass   = 0;
    int n_checks = 0;
    int cyc      = 0;
    int evt_seen = 0;

    // Model: pad-sample pipeline, time since enable, run of differing samples.
    bit m_pipe[$];
    bit m_on;
    int m_age;
    bit m_lvl;
    int m_run;
    bit m_evt, m_irq, m_pe, m_ps;

    always #5 clk = ~clk;

    gpi_rx_filter #(
        .SYNC_STAGES(S),
        .CNT_W      (CW)
    ) dut (
        .CLK_I     (clk),
        .RST_I     (rst),
        .DI_I      (di),
        .IE_O      (ie),
        .PE_O      (pe),
        .PS_O      (ps),
        .EN_I      (en),
        .PULL_I    (pull),
        .DEB_I     (deb),
        .EDGE_SEL_I(edge_sel),
        .CLR_I     (clr),
        .LVL_O     (lvl),
        .EVT_O     (evt),
        .IRQ_O     (irq)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
    endtask

    task automatic model_edge();
        bit seen;
        bit evt_next;
        bit irq_next;
        if (rst) begin
            m_pipe.delete();
            repeat (S) m_pipe.push_back(1'b0);
            m_on = 0; m_age = 0; m_lvl = 0; m_run = 0;
            m_evt = 0; m_irq = 0; m_pe = 0; m_ps = 0;
            return;
        end
        seen = m_pipe.pop_front();
        m_pipe.push_back(di);
        m_pe     = (pull == 2'd1) || (pull == 2'd2);
        m_ps     = (pull == 2'd2);
        irq_next = m_evt | (m_irq & !clr);
        evt_next = 0;
        if (!en) begin
            m_on = 0; m_lvl = 0; m_run = 0;
        end else if (!m_on) begin
            m_on = 1; m_age = 0;
        end else begin
            if (m_age < S + 2) m_age++;
            if (m_age == S + 1) begin
                m_lvl = seen;
                m_run = 0;
            end else if (m_age == S + 2) begin
                if (seen != m_lvl) begin
                    m_run++;
                    if (m_run >= int'(deb) + 1) begin
                        m_lvl    = seen;
                        m_run    = 0;
                        evt_next = (edge_sel == 2'd3) ||
                                   (seen ? (edge_sel == 2'd1) : (edge_sel == 2'd2));
                    end
                end else begin
                    m_run = 0;
                end
            end
        end
        m_evt = evt_next;
        m_irq = irq_next;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        check("lvl", lvl, m_lvl);
        check("evt", evt, m_evt);
        check("irq", irq, m_irq);
        check("ie",  ie,  m_on);
        check("pe",  pe,  m_pe);
        check("ps",  ps,  m_ps);
        if (evt === 1'b1) evt_seen++;
    endtask

    initial begin
        bit found;
        int hold;
        repeat (S) m_pipe.push_back(1'b0);

        // Reset with every input active: all outputs must stay low.
        rst = 1; di = 1; en = 1; clr = 1; pull = 2'b10; edge_sel = 2'b11; deb = '0;
        repeat (3) tick();
        check("rst_lvl", lvl, 1'b0);
        check("rst_ie", ie, 1'b0);

        // Enable with pad high and no debounce.
        rst = 0; clr = 0; pull = 2'b00;
        tick();
        check("ie_after_en", ie, 1'b1);
        evt_seen = 0;
        repeat (6) tick();
        check("lvl_after_settle", lvl, 1'b1);
        check("no_evt_in_settle", evt_seen == 0, 1'b1);

        // Debounce of 3: a 3-cycle low glitch is rejected, a 4-cycle low is taken.
        deb = CW'(3); edge_sel = 2'b10; evt_seen = 0;
        di = 0; repeat (3) tick();
        di = 1; repeat (8) tick();
        check("glitch3_held", lvl, 1'b1);
        di = 0; repeat (4) tick();
        di = 1; repeat (3) tick();
        di = 0; repeat (10) tick();
        check("low4_taken", lvl, 1'b0);
        check("fall_evt_once", evt_seen == 1, 1'b1);

        // Rise-only selection: rising edge raises an event, falling edge does not.
        clr = 1; tick(); clr = 0;
        edge_sel = 2'b01; deb = CW'(1); evt_seen = 0;
        di = 1; repeat (8) tick();
        check("rise_lvl", lvl, 1'b1);
        check("rise_evt_once", evt_seen == 1, 1'b1);
        check("rise_irq", irq, 1'b1);
        clr = 1; tick(); clr = 0;
        evt_seen = 0;
        di = 0; repeat (8) tick();
        check("fall_lvl", lvl, 1'b0);
        check("fall_no_evt", evt_seen == 0, 1'b1);
        check("fall_no_irq", irq, 1'b0);

        // Clear coinciding with the event loses to the set; clear alone wins.
        di = 1; found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (evt === 1'b1) found = 1;
        end
        check("evt_for_clr_seen", found, 1'b1);
        clr = 1; tick();
        check("irq_set_wins", irq, 1'b1);
        tick();
        check("irq_cleared", irq, 1'b0);
        clr = 0;

        // Disable mid-qualify, then re-enable through a full settle.
        edge_sel = 2'b11; deb = '0;
        di = 1; repeat (4) tick();
        di = 0; repeat (6) tick();
        di = 1; repeat (6) tick();
        check("irq_before_drop", irq, 1'b1);
        deb = CW'(6);
        di = 0; repeat (S + 3) tick();
        check("qualify_lvl_held", lvl, 1'b1);
        en = 0; di = 1; tick();
        check("drop_lvl", lvl, 1'b0);
        check("drop_ie", ie, 1'b0);
        check("drop_irq_kept", irq, 1'b1);
        en = 1; tick();
        check("reen_ie", ie, 1'b1);
        repeat (S) tick();
        check("resettle_hold", lvl, 1'b0);
        tick();
        check("resettle_done", lvl, 1'b1);

        // Pull decode, then reset mid-qualify.
        pull = 2'b10; tick();
        check("pull_up_pe", pe, 1'b1);
        check("pull_up_ps", ps, 1'b1);
        pull = 2'b11; tick();
        check("pull_11_pe", pe, 1'b0);
        pull = 2'b01; tick();
        check("pull_dn_ps", ps, 1'b0);
        di = 0; repeat (S + 3) tick();
        rst = 1; tick();
        check("rst_mid_lvl", lvl, 1'b0);
        check("rst_mid_irq", irq, 1'b0);
        check("rst_mid_pe", pe, 1'b0);
        check("rst_mid_ie", ie, 1'b0);
        rst = 0;

        // Randomized pad activity with occasional reconfiguration.
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                di   = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 7));
            end
            hold--;
            if ($urandom_range(0, 49) == 0) deb = CW'($urandom_range(0, 4));
            if ($urandom_range(0, 29) == 0) edge_sel = 2'($urandom_range(0, 3));
            clr  = ($urandom_range(0, 15) == 0);
            en   = ($urandom_range(0, 99) != 0);
            pull = 2'($urandom_range(0, 3));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
